hamming_secded_serial_rx: RTL and testbench
===========================================

// Module: hamming_secded_serial_rx
// PURPOSE
//  Parametrised serial Hamming SECDED receiver; successor to the fixed 128-bit serial decoder.
//  Deserialises one codeword, builds syndrome + overall parity incrementally per bit (no wide XOR tree),
//  corrects single errors, flags double errors, presents data on a valid/ready output. Sits between serial link RX and datapath.
// PARAMETERS
//  DATA_W   128  payload bits (>=4)
//  PAR_W    derived localparam: smallest r with 2**r >= DATA_W+r+1 (8 for 128, 3 for 4)
//  CODE_W   derived localparam: DATA_W+PAR_W; frame length FRAME_W = CODE_W+1 (overall parity appended)
// PORTS
//  clk          in   1       rising-edge clock
//  reset_n      in   1       asynchronous, active-low reset
//  start        in   1       frame start pulse; honoured only in IDLE
//  serial_in    in   1       serial code bit
//  bit_valid    in   1       serial_in is valid this cycle
//  in_ready     out  1       receiver accepts bits (high in IDLE/RECV)
//  dout         out  DATA_W  corrected payload
//  dout_valid   out  1       dout/flags valid; held until dout_ready
//  dout_ready   in   1       downstream accepts
//  err_single   out  1       single error detected and corrected
//  err_double   out  1       uncorrectable error; dout = uncorrected data
//  err_pos      out  PAR_W   syndrome (corrected position, 0 = overall-parity bit or none)
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, dout=0, dout_valid=0, err_*=0, err_pos=0, counters/accumulators=0; any frame in flight discarded.
//  Code layout: positions 1..CODE_W; parity at powers of two; data[0] at pos 3, then ascending non-power-of-two positions.
//  Serial order: pos 1 first, ascending to CODE_W, then overall parity bit (even parity over positions 1..CODE_W).
//  FSM: IDLE -start-> RECV (bit counter=0). RECV: on bit_valid&in_ready store bit at pos cnt+1,
//   if bit=1 syn^=pos (pos<=CODE_W) and ovr^=1 (all bits); on the FRAME_W-th accepted bit -> CHECK.
//   bit_valid low in RECV = stall, no state change. start in RECV/CHECK/OUT ignored.
//  CHECK (1 cycle): ovr=0,syn=0 -> clean; ovr=1,syn in 1..CODE_W -> flip pos syn, err_single=1;
//   ovr=1,syn=0 -> overall-parity bit error, data untouched, err_single=1;
//   ovr=0,syn!=0 or ovr=1,syn>CODE_W -> err_double=1, no flip. Register dout/flags/err_pos, dout_valid=1 -> OUT.
//  Latency: dout_valid rises at the 2nd rising edge after the edge sampling the final frame bit.
//  OUT: dout, err_*, err_pos stable while dout_valid&!dout_ready; in_ready=0. On dout_valid&dout_ready:
//   dout_valid=0, err_* cleared, syn/ovr/cnt cleared -> IDLE (dout keeps last value). start in same cycle ignored.
//  Back-to-back: next start accepted earliest in the cycle after the handshake.
//  Counter width $clog2(FRAME_W+1); no wrap possible (terminates at FRAME_W).
// CONFIGURATION
//  HAM_SECDED_ERR_CNT_EN defined: adds ports cnt_clr (in,1), cnt_single (out,16), cnt_double (out,16);
//   increment by 1 in CHECK on err_single / err_double, saturate at 16'hFFFF, cnt_clr synchronous clear (wins over increment),
//   reset to 0. Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  DATA_W=128, data=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, clean frame -> dout=data, err_single=0, err_double=0, err_pos=0.
//  Same data, pos 3 flipped -> dout=data, err_single=1, err_pos=8'd3; pos 128 (parity) flipped -> dout=data, err_pos=8'd128.
//  Flip overall parity bit only -> dout=data, err_single=1, err_pos=0; flip pos 5 and 9 -> err_double=1, err_pos=8'd12, dout=uncorrected.
//  dout_ready=0 for 10 cycles after dout_valid -> dout/flags stable, in_ready=0, start pulses ignored; ready=1 -> IDLE next cycle.
//  reset_n low at bit 60 of a frame -> all outputs 0 immediately; fresh frame afterwards decodes correctly; bit_valid gaps of 3 cycles mid-frame -> same result.
//  DATA_W=4 (PAR_W=3, 8-bit frame), data=4'hB, pos 6 flipped -> dout=4'hB, err_pos=3'd6; with HAM_SECDED_ERR_CNT_EN cnt_single=1.

Source files
------------

// File: rtl/hamming_secded_serial_rx.sv
// Serial Hamming SECDED receiver: accumulates syndrome/overall parity bit by bit, corrects single, flags double errors.
// Optional per-error-class event counters enabled by defining HAM_SECDED_ERR_CNT_EN.
module hamming_secded_serial_rx #(
  parameter int  DATA_W = 128,
  localparam int PAR_W  = $clog2(DATA_W + $clog2(DATA_W) + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              serial_in,
  input  logic              bit_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              err_single,
  output logic              err_double,
`ifdef HAM_SECDED_ERR_CNT_EN
  output logic [PAR_W-1:0]  err_pos,
  input  logic              cnt_clr,
  output logic [15:0]       cnt_single,
  output logic [15:0]       cnt_double
`else
  output logic [PAR_W-1:0]  err_pos
`endif
);

  localparam int CODE_W  = DATA_W + PAR_W;
  localparam int FRAME_W = CODE_W + 1;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_SYND, S_CHECK, S_OUT} state_t;
  typedef enum logic [1:0] {C_CLEAN, C_FIX, C_FIX_OVR, C_DOUBLE} cls_t;

  // Code position carrying payload bit idx (ascending non-power-of-two positions).
  function automatic int data_pos(input int idx);
    int k;
    int p;
    k = 0;
    p = 0;
    for (int q = 1; q <= CODE_W; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (k == idx) p = q;
        k++;
      end
    end
    return p;
  endfunction

  state_t              state_q, state_d;
  cls_t                cls_q, cls_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PAR_W-1:0]    syn_q, syn_d;
  logic                ovr_q, ovr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                err_single_q, err_single_d;
  logic                err_double_q, err_double_d;
  logic [PAR_W-1:0]    err_pos_q, err_pos_d;
`ifdef HAM_SECDED_ERR_CNT_EN
  logic [15:0]         cnt_single_q, cnt_single_d;
  logic [15:0]         cnt_double_q, cnt_double_d;
`endif

  logic [CNT_W-1:0]    pos;
  logic                pos_is_par;
  logic                pos_in_code;
  logic [DATA_W-1:0]   flip_mask;

  assign pos         = cnt_q + CNT_W'(1);
  assign pos_is_par  = (pos & (pos - CNT_W'(1))) == '0;
  assign pos_in_code = pos <= CNT_W'(CODE_W);

  // Each payload bit compares the syndrome against its own constant position.
  for (genvar i = 0; i < DATA_W; i++) begin : g_flip
    localparam int POS = data_pos(i);
    assign flip_mask[i] = (cls_q == C_FIX) && (syn_q == PAR_W'(POS));
  end

  always_comb begin
    // NOTE: every *_d gets a default first, so no path through the case infers a latch.
    state_d      = state_q;
    cls_d        = cls_q;
    cnt_d        = cnt_q;
    syn_d        = syn_q;
    ovr_d        = ovr_q;
    data_d       = data_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    err_single_d = err_single_q;
    err_double_d = err_double_q;
    err_pos_d    = err_pos_q;
`ifdef HAM_SECDED_ERR_CNT_EN
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RECV;
          cnt_d   = '0;
          syn_d   = '0;
          ovr_d   = 1'b0;
        end
      end
      S_RECV: begin
        if (bit_valid) begin
          cnt_d = pos;
          if (serial_in) begin
            ovr_d = ~ovr_q;
            if (pos_in_code) syn_d = syn_q ^ pos[PAR_W-1:0];
          end
          // Payload bits arrive in ascending index order, so a right shift lands data[0] at bit 0.
          if (pos_in_code && !pos_is_par) data_d = {serial_in, data_q[DATA_W-1:1]};
          if (cnt_q == CNT_W'(FRAME_W - 1)) state_d = S_SYND;
        end
      end
      S_SYND: begin
        if (!ovr_q)                        cls_d = (syn_q == '0) ? C_CLEAN : C_DOUBLE;
        else if (syn_q == '0)              cls_d = C_FIX_OVR;
        else if (syn_q <= PAR_W'(CODE_W))  cls_d = C_FIX;
        else                               cls_d = C_DOUBLE;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        dout_d       = data_q ^ flip_mask;
        err_single_d = (cls_q == C_FIX) || (cls_q == C_FIX_OVR);
        err_double_d = (cls_q == C_DOUBLE);
        err_pos_d    = syn_q;
        dout_valid_d = 1'b1;
        state_d      = S_OUT;
`ifdef HAM_SECDED_ERR_CNT_EN
        if (err_single_d && cnt_single_q != 16'hFFFF) cnt_single_d = cnt_single_q + 16'd1;
        if (err_double_d && cnt_double_q != 16'hFFFF) cnt_double_d = cnt_double_q + 16'd1;
`endif
      end
      S_OUT: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          err_single_d = 1'b0;
          err_double_d = 1'b0;
          err_pos_d    = '0;
          syn_d        = '0;
          ovr_d        = 1'b0;
          cnt_d        = '0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef HAM_SECDED_ERR_CNT_EN
    if (cnt_clr) begin
      cnt_single_d = '0;
      cnt_double_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cls_q        <= C_CLEAN;
      cnt_q        <= '0;
      syn_q        <= '0;
      ovr_q        <= 1'b0;
      // NOTE: the payload shift register is reset too, so a frame cut short by reset leaves no stale bits.
      data_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      err_single_q <= 1'b0;
      err_double_q <= 1'b0;
      err_pos_q    <= '0;
`ifdef HAM_SECDED_ERR_CNT_EN
      cnt_single_q <= '0;
      cnt_double_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge value of its neighbours.
      state_q      <= state_d;
      cls_q        <= cls_d;
      cnt_q        <= cnt_d;
      syn_q        <= syn_d;
      ovr_q        <= ovr_d;
      data_q       <= data_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      err_single_q <= err_single_d;
      err_double_q <= err_double_d;
      err_pos_q    <= err_pos_d;
`ifdef HAM_SECDED_ERR_CNT_EN
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
`endif
    end
  end

  assign in_ready   = (state_q == S_IDLE) || (state_q == S_RECV);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign err_single = err_single_q;
  assign err_double = err_double_q;
  assign err_pos    = err_pos_q;
`ifdef HAM_SECDED_ERR_CNT_EN
  assign cnt_single = cnt_single_q;
  assign cnt_double = cnt_double_q;
`endif

endmodule

// File: tb/tb_hamming_secded_serial_rx.sv
// Bench for hamming_secded_serial_rx: a 128-bit and a 4-bit instance checked against an injection-based model.
// Build with HAM_SECDED_ERR_CNT_EN defined to also check the error counters.
module tb_hamming_secded_serial_rx;

  localparam int CWA = 136;  // DATA_W=128, PAR_W=8
  localparam int CWB = 7;    // DATA_W=4,   PAR_W=3
  localparam logic [127:0] D128 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  typedef struct {
    logic [127:0] data;
    logic         s;
    logic         d;
    int           pos;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic start_s [2];
  logic sin_s   [2];
  logic bv_s    [2];
  logic dr_s    [2];

  logic         ir_a, dv_a, es_a, ed_a;
  logic [127:0] dout_a;
  logic [7:0]   ep_a;
  logic         ir_b, dv_b, es_b, ed_b;
  logic [3:0]   dout_b;
  logic [2:0]   ep_b;
`ifdef HAM_SECDED_ERR_CNT_EN
  logic         clr_s [2];
  logic [15:0]  cs_a, cd_a, cs_b, cd_b;
  int           ecs [2];
  int           ecd [2];
`endif

  hamming_secded_serial_rx #(.DATA_W(128)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_s[0]), .serial_in(sin_s[0]), .bit_valid(bv_s[0]),
    .in_ready(ir_a), .dout(dout_a), .dout_valid(dv_a), .dout_ready(dr_s[0]),
    .err_single(es_a), .err_double(ed_a),
`ifdef HAM_SECDED_ERR_CNT_EN
    .err_pos(ep_a), .cnt_clr(clr_s[0]), .cnt_single(cs_a), .cnt_double(cd_a)
`else
    .err_pos(ep_a)
`endif
  );

  hamming_secded_serial_rx #(.DATA_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_s[1]), .serial_in(sin_s[1]), .bit_valid(bv_s[1]),
    .in_ready(ir_b), .dout(dout_b), .dout_valid(dv_b), .dout_ready(dr_s[1]),
    .err_single(es_b), .err_double(ed_b),
`ifdef HAM_SECDED_ERR_CNT_EN
    .err_pos(ep_b), .cnt_clr(clr_s[1]), .cnt_single(cs_b), .cnt_double(cd_b)
`else
    .err_pos(ep_b)
`endif
  );

  int   tests = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] f_dout(input int s); return (s == 0) ? dout_a : 128'(dout_b); endfunction
  function automatic logic [127:0] f_ep(input int s);   return (s == 0) ? 128'(ep_a) : 128'(ep_b); endfunction
  function automatic logic f_dv(input int s); return (s == 0) ? dv_a : dv_b; endfunction
  function automatic logic f_ir(input int s); return (s == 0) ? ir_a : ir_b; endfunction
  function automatic logic f_es(input int s); return (s == 0) ? es_a : es_b; endfunction
  function automatic logic f_ed(input int s); return (s == 0) ? ed_a : ed_b; endfunction

  // Codeword indexed by position: bit p = position p, bit cw+1 = overall parity.
  function automatic logic [255:0] encode(input logic [127:0] d, input int cw);
    logic [255:0] c;
    logic         x;
    int           k;
    c = '0;
    k = 0;
    for (int p = 1; p <= cw; p++) if ((p & (p - 1)) != 0) begin c[p] = d[k]; k++; end
    for (int p = 1; p <= cw; p = p * 2) begin
      x = 1'b0;
      for (int q = p + 1; q <= cw; q++) if ((q & p) != 0) x ^= c[q];
      c[p] = x;
    end
    x = 1'b0;
    for (int p = 1; p <= cw; p++) x ^= c[p];
    c[cw + 1] = x;
    return c;
  endfunction

  function automatic logic [127:0] extract(input logic [255:0] c, input int cw);
    logic [127:0] d;
    int           k;
    d = '0;
    k = 0;
    for (int p = 1; p <= cw; p++) if ((p & (p - 1)) != 0) begin d[k] = c[p]; k++; end
    return d;
  endfunction

  // Expected result follows from what was injected: 0 flips clean, 1 flip corrected, 2 flips flagged.
  function automatic exp_t expect_of(input logic [127:0] d, input logic [255:0] rx, input int cw,
                                     input int f1, input int f2);
    exp_t e;
    e.data = d;
    e.s = 1'b0;
    e.d = 1'b0;
    e.pos = 0;
    if (f1 != 0 && f2 != 0) begin
      e.d = 1'b1;
      e.pos = ((f1 <= cw) ? f1 : 0) ^ ((f2 <= cw) ? f2 : 0);
      e.data = extract(rx, cw);
    end else if (f1 != 0) begin
      e.s = 1'b1;
      e.pos = (f1 <= cw) ? f1 : 0;
    end
    return e;
  endfunction

  // gap: 0 none, >0 a stall of that many cycles every 20 bits, <0 random short stalls.
  task automatic send(input int s, input logic [127:0] d, input int f1, input int f2, input int gap);
    int           cw;
    logic [255:0] c;
    exp_t         e;
    cw = (s == 0) ? CWA : CWB;
    c = encode(d, cw);
    if (f1 != 0) c[f1] = ~c[f1];
    if (f2 != 0) c[f2] = ~c[f2];
    e = expect_of(d, c, cw, f1, f2);
    if (s == 0) q0.push_back(e); else q1.push_back(e);
`ifdef HAM_SECDED_ERR_CNT_EN
    if (e.s) ecs[s]++;
    if (e.d) ecd[s]++;
`endif
    check("in_ready_idle", 128'(f_ir(s)), 1);
    start_s[s] = 1'b1;
    @(posedge clk); #1;
    start_s[s] = 1'b0;
    for (int p = 1; p <= cw + 1; p++) begin
      if ((gap > 0 && p % 20 == 10) || (gap < 0 && $urandom_range(0, 7) == 0)) begin
        repeat ((gap > 0) ? gap : int'($urandom_range(1, 3))) @(posedge clk);
        #1;
      end
      sin_s[s] = c[p];
      bv_s[s] = 1'b1;
      @(posedge clk); #1;
      bv_s[s] = 1'b0;
    end
    check("latency_e0", 128'(f_dv(s)), 0);
    @(posedge clk); #1;
    check("latency_e1", 128'(f_dv(s)), 0);
    @(posedge clk); #1;
    check("latency_e2", 128'(f_dv(s)), 1);
  endtask

  task automatic recv(input int s, input int hold);
    for (int i = 0; i < hold; i++) begin
      start_s[s] = (i % 3 == 1);
      @(posedge clk); #1;
    end
    start_s[s] = 1'b0;
    dr_s[s] = 1'b1;
    @(posedge clk); #1;
    dr_s[s] = 1'b0;
    check("hs_dv_clear", 128'(f_dv(s)), 0);
    check("hs_idle", 128'(f_ir(s)), 1);
    check("hs_err_clear", 128'({f_es(s), f_ed(s)}), 0);
  endtask

  task automatic rand_frame(input int s);
    int fw, n, f1, f2;
    logic [127:0] d;
    fw = ((s == 0) ? CWA : CWB) + 1;
    d = {$urandom, $urandom, $urandom, $urandom};
    if (s == 1) d = d & 128'hF;
    n = $urandom_range(0, 2);
    f1 = 0;
    f2 = 0;
    if (n >= 1) f1 = $urandom_range(1, fw);
    if (n == 2) begin
      f2 = $urandom_range(1, fw);
      while (f2 == f1) f2 = $urandom_range(1, fw);
    end
    send(s, d, f1, f2, -1);
    recv(s, $urandom_range(0, 3));
  endtask

  // Single compare process: whenever a result is presented it must match the head of the model queue.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int s = 0; s < 2; s++) begin
        if (f_dv(s)) begin
          exp_t e;
          if ((s == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e = (s == 0) ? q0[0] : q1[0];
            check("cmp_dout", f_dout(s), e.data);
            check("cmp_err_single", 128'(f_es(s)), 128'(e.s));
            check("cmp_err_double", 128'(f_ed(s)), 128'(e.d));
            check("cmp_err_pos", f_ep(s), 128'(e.pos));
            check("cmp_in_ready_out", 128'(f_ir(s)), 0);
            if (dr_s[s]) begin
              if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #600000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      start_s[s] = 1'b0; sin_s[s] = 1'b0; bv_s[s] = 1'b0; dr_s[s] = 1'b0;
`ifdef HAM_SECDED_ERR_CNT_EN
      clr_s[s] = 1'b0; ecs[s] = 0; ecd[s] = 0;
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_dout", f_dout(s), 0);
      check("rst_flags", 128'({f_dv(s), f_es(s), f_ed(s)}), 0);
      check("rst_err_pos", f_ep(s), 0);
      check("rst_in_ready", 128'(f_ir(s)), 1);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Hand-computed literal expectations pinning the model on the 128-bit instance.
    send(0, D128, 0, 0, 0);
    check("pin_clean_dout", dout_a, D128);
    check("pin_clean_flags", {es_a, ed_a, ep_a}, 0);
    recv(0, 0);
    send(0, D128, 3, 0, 0);
    check("pin_p3_dout", dout_a, D128);
    check("pin_p3_single", es_a, 1);
    check("pin_p3_pos", ep_a, 8'd3);
    recv(0, 1);
    send(0, D128, 128, 0, 0);
    check("pin_p128_dout", dout_a, D128);
    check("pin_p128_pos", ep_a, 8'd128);
    recv(0, 0);
    send(0, D128, CWA + 1, 0, 0);
    check("pin_ovr_dout", dout_a, D128);
    check("pin_ovr_single", es_a, 1);
    check("pin_ovr_pos", ep_a, 0);
    recv(0, 0);
    send(0, D128, 5, 9, 0);
    check("pin_dbl_flag", ed_a, 1);
    check("pin_dbl_pos", ep_a, 8'd12);
    check("pin_dbl_dout", dout_a, D128 ^ 128'h12);
    recv(0, 0);

    // Back-pressure: result held for 10 cycles while start pulses are ignored.
    send(0, D128, 0, 0, 0);
    recv(0, 10);

    // Reset in the middle of a frame discards it.
    begin
      logic [255:0] c;
      c = encode(D128, CWA);
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      for (int p = 1; p <= 60; p++) begin
        sin_s[0] = c[p];
        bv_s[0] = 1'b1;
        @(posedge clk); #1;
      end
      bv_s[0] = 1'b0;
      reset_n = 1'b0;
      #1;
      check("midrst_dout", dout_a, 0);
      check("midrst_flags", {dv_a, es_a, ed_a, ep_a}, 0);
`ifdef HAM_SECDED_ERR_CNT_EN
      check("midrst_cnt", {cs_a, cd_a, cs_b, cd_b}, 0);
      for (int s = 0; s < 2; s++) begin ecs[s] = 0; ecd[s] = 0; end
`endif
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
    end
    send(0, D128, 0, 0, 3);
    check("gap_dout", dout_a, D128);
    recv(0, 0);

    for (int i = 0; i < 20; i++) rand_frame(0);

    // Narrow instance.
`ifdef HAM_SECDED_ERR_CNT_EN
    clr_s[1] = 1'b1;
    @(posedge clk); #1;
    clr_s[1] = 1'b0;
    ecs[1] = 0;
    ecd[1] = 0;
`endif
    send(1, 128'hB, 6, 0, 0);
    check("pin4_dout", dout_b, 4'hB);
    check("pin4_pos", ep_b, 3'd6);
    check("pin4_single", es_b, 1);
`ifdef HAM_SECDED_ERR_CNT_EN
    check("pin4_cnt_single", cs_b, 16'd1);
`endif
    recv(1, 2);
    for (int i = 0; i < 30; i++) rand_frame(1);

`ifdef HAM_SECDED_ERR_CNT_EN
    check("cnt_single_a", cs_a, 128'(ecs[0]));
    check("cnt_double_a", cd_a, 128'(ecd[0]));
    check("cnt_single_b", cs_b, 128'(ecs[1]));
    check("cnt_double_b", cd_b, 128'(ecd[1]));
`endif
    check("queues_drained", 128'(q0.size() + q1.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
